pin_capt_mc: RTL

PIN_CAPT_MC -- requirements
Module: pin_capt_mc

---
 rtl/pin_capt_pkg.sv | 29 ++
 rtl/pin_edge_det.sv | 59 +++++
 rtl/pin_capt_mc.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pin_capt_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pin_capt_pkg : shared edge-mode, event record and defaults for pin capture
// rev 1.0
// ----------------------------------------------------------------------------
package pin_capt_pkg;

  localparam int PIN_CHANNELS_DEF   = 4;
  localparam int PIN_OSR_DEF        = 8;
  localparam int PIN_CT_W_DEF       = 16;
  localparam int PIN_FIFO_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } edge_mode_e;

  // Event record at the default geometry
  typedef struct packed {
    logic [$clog2(PIN_CHANNELS_DEF)-1:0]             chan;
    logic [PIN_CT_W_DEF+$clog2(PIN_OSR_DEF)-1:0]     ts;
    logic                                            pol;
    logic                                            multi;
  } pin_event_t;

endpackage
`default_nettype wire

// File: rtl/pin_edge_det.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pin_edge_det : per-channel edge finder over one oversampled word
// rev 1.0
// ----------------------------------------------------------------------------
module pin_edge_det
  import pin_capt_pkg::*;
#(
  parameter  int OSR = PIN_OSR_DEF,
  localparam int FW  = $clog2(OSR)
) (
  input  logic          clk300,
  input  logic          rst_n,
  input  logic          en,
  input  logic [OSR-1:0] word,
  input  logic [1:0]    mode,
  output logic          hit,
  output logic [FW-1:0] fine,
  output logic          pol,
  output logic          multi
);

  logic           prev_q, prev_d;
  logic [OSR-1:0] shifted, rise, fall, qual;
  edge_mode_e     mode_e;

  always_comb begin
    mode_e  = edge_mode_e'(mode);
    prev_d  = word[OSR-1];
    // each sample compared with its predecessor; sample 0 against the last word
    shifted = {word[OSR-2:0], prev_q};
    rise    = word & ~shifted;
    fall    = ~word & shifted;
    qual    = '0;
    if (en) begin
      case (mode_e)
        MODE_RISE: qual = rise;
        MODE_FALL: qual = fall;
        MODE_BOTH: qual = rise | fall;
        MODE_OFF:  qual = '0;
        default:   qual = '0;
      endcase
    end
    hit   = |qual;
    multi = ($countones(qual) > 1);
    fine  = '0;
    for (int k = OSR - 1; k >= 0; k--) begin
      if (qual[k]) fine = FW'(k);
    end
    pol = word[fine];
  end

  always_ff @(posedge clk300 or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= prev_d;
  end

endmodule
`default_nettype wire

// File: rtl/pin_capt_mc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pin_capt_mc : multi-channel oversampled edge capture with timestamped FIFO
// rev 1.0
// ----------------------------------------------------------------------------
module pin_capt_mc
  import pin_capt_pkg::*;
#(
  parameter  int CHANNELS   = PIN_CHANNELS_DEF,
  parameter  int OSR        = PIN_OSR_DEF,
  parameter  int CT_W       = PIN_CT_W_DEF,
  parameter  int FIFO_DEPTH = PIN_FIFO_DEPTH_DEF,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int FW         = $clog2(OSR),
  localparam int TS_W       = CT_W + FW
) (
  input  logic                    clk300,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [CHANNELS*OSR-1:0] samples,
  input  logic [2*CHANNELS-1:0]   cfg_mode,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic [CH_W-1:0]         ev_chan,
  output logic [TS_W-1:0]         ev_ts,
  output logic                    ev_pol,
  output logic                    ev_multi,
  output logic [CHANNELS-1:0]     ovf,
  input  logic                    ovf_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic            pol;
    logic            multi;
  } pend_t;

  typedef struct packed {
    logic [CH_W-1:0] chan;
    logic [TS_W-1:0] ts;
    logic            pol;
    logic            multi;
  } fifo_ent_t;

  logic [CT_W-1:0]     ct_q, ct_d;
  logic [CHANNELS-1:0] hit, pol, multi;
  logic [FW-1:0]       fine [CHANNELS];
  logic [CHANNELS-1:0] pend_vld_q, pend_vld_d, ovf_q, ovf_d, gnt;
  pend_t               pend_q [CHANNELS];
  pend_t               pend_d [CHANNELS];
  logic [CH_W-1:0]     ptr_q, ptr_d, gnt_idx;
  logic                gnt_vld;
  int                  arb_idx;
  logic [AW:0]         wr_q, wr_d, rd_q, rd_d;
  fifo_ent_t           mem_q [FIFO_DEPTH];
  fifo_ent_t           wr_ent, head;
  logic                full, empty, push, pop;

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      pin_edge_det #(.OSR(OSR)) u_det (
        .clk300 (clk300),
        .rst_n  (rst_n),
        .en     (en),
        .word   (samples[c*OSR +: OSR]),
        .mode   (cfg_mode[2*c +: 2]),
        .hit    (hit[c]),
        .fine   (fine[c]),
        .pol    (pol[c]),
        .multi  (multi[c])
      );
    end
  endgenerate

  always_comb begin
    empty = (wr_q == rd_q);
    full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop   = !empty && ev_ready;
    ct_d  = ct_q + CT_W'(1);

    // round-robin search starting at the pointer
    gnt     = '0;
    gnt_vld = 1'b0;
    gnt_idx = ptr_q;
    arb_idx = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      arb_idx = (int'(ptr_q) + i) % CHANNELS;
      if (!gnt_vld && !full && pend_vld_q[arb_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = CH_W'(arb_idx);
      end
    end
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
    ptr_d = ptr_q;
    if (gnt_vld) ptr_d = (int'(gnt_idx) == CHANNELS - 1) ? '0 : gnt_idx + CH_W'(1);

    push         = gnt_vld;
    wr_ent.chan  = gnt_idx;
    wr_ent.ts    = pend_q[gnt_idx].ts;
    wr_ent.pol   = pend_q[gnt_idx].pol;
    wr_ent.multi = pend_q[gnt_idx].multi;
    wr_d = (push && (!full || pop)) ? wr_q + (AW+1)'(1) : wr_q;
    rd_d = pop ? rd_q + (AW+1)'(1) : rd_q;

    // a slot being granted this cycle is free for the incoming event
    for (int c = 0; c < CHANNELS; c++) begin
      pend_vld_d[c] = (pend_vld_q[c] && !gnt[c]) || hit[c];
      pend_d[c]     = pend_q[c];
      if (hit[c] && (!pend_vld_q[c] || gnt[c])) begin
        pend_d[c].ts    = {ct_q, fine[c]};
        pend_d[c].pol   = pol[c];
        pend_d[c].multi = multi[c];
      end
      ovf_d[c] = (ovf_q[c] && !ovf_clr) || (hit[c] && pend_vld_q[c] && !gnt[c]);
    end
  end

  always_ff @(posedge clk300 or negedge rst_n) begin
    if (!rst_n) begin
      ct_q       <= '0;
      ptr_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      pend_vld_q <= '0;
      ovf_q      <= '0;
      for (int c = 0; c < CHANNELS; c++) pend_q[c] <= '0;
    end else begin
      ct_q       <= ct_d;
      ptr_q      <= ptr_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      pend_vld_q <= pend_vld_d;
      ovf_q      <= ovf_d;
      for (int c = 0; c < CHANNELS; c++) pend_q[c] <= pend_d[c];
    end
  end

  // storage only; validity is tracked by the reset pointers
  always_ff @(posedge clk300) begin
    if (push && (!full || pop)) mem_q[wr_q[AW-1:0]] <= wr_ent;
  end

  assign head     = mem_q[rd_q[AW-1:0]];
  assign ev_valid = !empty;
  assign ev_chan  = head.chan;
  assign ev_ts    = head.ts;
  assign ev_pol   = head.pol;
  assign ev_multi = head.multi;
  assign ovf      = ovf_q;

endmodule
`default_nettype wire
